// File: rtl/audio_lpf.sv
// Mixer-output recovery: boxcar decimator (accumulate-and-dump) followed by a one-pole IIR.
// Produces a signed OW-bit sample and a one-clock strobe per decimated block.
module audio_lpf #(
   parameter int unsigned IW    = 11,
   parameter int unsigned OW    = 16,
   parameter int unsigned DECIM = 64,
   parameter int unsigned K     = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic [IW-1:0] audio_in,
   input  logic          mute,
   output logic [OW-1:0] sample_out,
   output logic          sample_valid
);

   localparam int unsigned CW = $clog2(DECIM);
   localparam int unsigned AW = IW + CW;

   logic [AW-1:0]      acc_q, acc_d, sum;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      avg_q, avg_d;
   logic               dump_q, dump_d;
   logic signed [OW:0] y_q, y_d, x, diff;
   logic signed [IW:0] ctr;
   logic [OW-1:0]      out_q, out_d;
   logic               valid_q, valid_d;

   // Stage 1: accumulate DECIM ce-qualified samples, then dump the block mean.
   always_comb begin
      sum    = acc_q + AW'(audio_in);
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      avg_d  = avg_q;
      dump_d = 1'b0;
      if (ce) begin
         if (cnt_q == CW'(DECIM - 1)) begin
            avg_d  = IW'(sum >> CW);
            acc_d  = '0;
            cnt_d  = '0;
            dump_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Stage 2: offset-binary to signed, scale to OW bits, then y += (x - y) >>> K.
   always_comb begin
      ctr     = $signed({1'b0, avg_q}) - $signed((IW + 1)'(1 << (IW - 1)));
      x       = mute ? '0 : ({{(OW - IW){ctr[IW]}}, ctr} <<< (OW - IW));
      diff    = x - y_q;
      y_d     = y_q;
      out_d   = out_q;
      valid_d = 1'b0;
      if (dump_q) begin
         y_d     = y_q + (diff >>> K);
         out_d   = y_d[OW-1:0];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         avg_q   <= '0;
         dump_q  <= 1'b0;
         y_q     <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         avg_q   <= avg_d;
         dump_q  <= dump_d;
         y_q     <= y_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign sample_out   = out_q;
   assign sample_valid = valid_q;

endmodule
